// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB writeback stage.
// Result-source and load-type encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } resultsrc_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Load data extraction by width, sign and byte offset.
// Also flags loads whose offset breaks natural alignment.
module load_formatter
  import wb_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (offset_i)
      2'd0:    byte_v = raw_i[7:0];
      2'd1:    byte_v = raw_i[15:8];
      2'd2:    byte_v = raw_i[23:16];
      default: byte_v = raw_i[31:24];
    endcase
    half_v = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  // Unknown funct3 codes fall through as a plain word, never misaligned
  always_comb begin
    data_o       = raw_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      LB: data_o = {{24{byte_v[7]}}, byte_v};
      LBU: data_o = {24'b0, byte_v};
      LH: begin
        data_o       = {{16{half_v[15]}}, half_v};
        misaligned_o = offset_i[0];
      end
      LHU: begin
        data_o       = {16'b0, half_v};
        misaligned_o = offset_i[0];
      end
      LW: misaligned_o = |offset_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB stage: load formatting, result select,
// register-file write qualification and retire counting.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int P_WIDTH     = 32,
  parameter int P_REG_ADDR  = 5,
  parameter int P_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid_m,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [P_WIDTH-1:0]     i_alu_result_m,
  input  logic [P_WIDTH-1:0]     i_mem_rdata_m,
  input  logic [P_WIDTH-1:0]     i_pc_plus_4_m,
  input  logic [P_WIDTH-1:0]     i_imm_m,
  input  logic [1:0]             i_resultsrc_m,
  input  logic [2:0]             i_funct3_m,
  input  logic [P_REG_ADDR-1:0]  i_rd_m,
  input  logic                   i_reg_write_m,
  output logic [P_WIDTH-1:0]     o_result_w,
  output logic [P_REG_ADDR-1:0]  o_rd_w,
  output logic                   o_reg_write_w,
  output logic                   o_valid_w,
  output logic                   o_misaligned_w,
  output logic [P_CNT_WIDTH-1:0] o_retired
);

  logic [P_WIDTH-1:0]     result_q, result_d;
  logic [P_REG_ADDR-1:0]  rd_q, rd_d;
  logic                   we_q, we_d;
  logic                   valid_q, valid_d;
  logic                   mis_q, mis_d;
  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [P_WIDTH-1:0] load_data;
  logic [P_WIDTH-1:0] sel_result;
  logic               fmt_mis;
  logic               mis_m;
  logic               we_m;

  load_formatter u_fmt (
    .raw_i        (i_mem_rdata_m),
    .offset_i     (i_alu_result_m[1:0]),
    .funct3_i     (i_funct3_m),
    .data_o       (load_data),
    .misaligned_o (fmt_mis)
  );

  always_comb begin
    sel_result = i_alu_result_m;
    unique case (resultsrc_e'(i_resultsrc_m))
      RES_ALU: sel_result = i_alu_result_m;
      RES_MEM: sel_result = load_data;
      RES_PC4: sel_result = i_pc_plus_4_m;
      RES_IMM: sel_result = i_imm_m;
    endcase
  end

  assign mis_m = i_valid_m & fmt_mis
               & (i_resultsrc_m == RES_MEM);
  assign we_m  = i_valid_m & i_reg_write_m & ~mis_m
               & (i_rd_m != '0);

  always_comb begin
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      result_d = '0;
      rd_d     = '0;
      we_d     = 1'b0;
      valid_d  = 1'b0;
      mis_d    = 1'b0;
    end else if (!i_stall) begin
      result_d = sel_result;
      rd_d     = i_rd_m;
      we_d     = we_m;
      valid_d  = i_valid_m;
      mis_d    = mis_m;
      // Misaligned loads stay visible in WB but do not retire
      if (i_valid_m && !mis_m)
        cnt_d = cnt_q + P_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_result_w     = result_q;
  assign o_rd_w         = rd_q;
  assign o_reg_write_w  = we_q;
  assign o_valid_w      = valid_q;
  assign o_misaligned_w = mis_q;
  assign o_retired      = cnt_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered MEM/WB pipeline stage plus writeback result selection for the RV32I core.
- Replaces the pure combinational result mux:
  - captures MEM-stage outputs on the clock edge;
  - formats load data by width, sign and byte offset;
  - selects one of four result sources;
  - drives register-file write signals.
- Adds stall and flush control, misaligned-load detection and a retired-instruction counter.

Parameters:
- P_WIDTH, 32, datapath width in bits. Only 32 is supported for load formatting.
- P_REG_ADDR, 5, register-file address width.
- P_CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid_m  input  1  MEM stage holds a valid instruction.
- i_stall  input  1  hold all WB registers at their current value.
- i_flush  input  1  load a bubble into WB.
- i_alu_result_m  input  P_WIDTH  ALU result; bits [1:0] give the load byte offset.
- i_mem_rdata_m  input  P_WIDTH  raw word read from data memory.
- i_pc_plus_4_m  input  P_WIDTH  PC+4, used for JAL/JALR.
- i_imm_m  input  P_WIDTH  U-immediate, used for LUI.
- i_resultsrc_m  input  2  00=ALU, 01=MEM, 10=PC+4, 11=IMM.
- i_funct3_m  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_rd_m  input  P_REG_ADDR  destination register.
- i_reg_write_m  input  1  instruction writes rd.
- o_result_w  output  P_WIDTH  data written to the register file and forwarded.
- o_rd_w  output  P_REG_ADDR  destination register.
- o_reg_write_w  output  1  register-file write enable, qualified.
- o_valid_w  output  1  WB holds a valid instruction.
- o_misaligned_w  output  1  the current WB load was misaligned.
- o_retired  output  P_CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (i_rst=1 at an edge): all outputs and internal registers go to 0; o_retired=0. Reset overrides stall and flush.
- Priority at each edge: i_rst > i_flush > i_stall > normal capture.
- Flush: o_valid_w=0, o_reg_write_w=0, o_misaligned_w=0. o_result_w and o_rd_w are don't-care; implement them as 0.
- Stall (without flush): every register holds, including the counter.
- Normal capture: result and control are computed combinationally from the *_m inputs and registered. Latency is exactly 1 cycle from M inputs to W outputs.
- Load formatting uses offset = i_alu_result_m[1:0]:
  - LB/LBU: byte at offset*8, sign- or zero-extended.
  - LH/LHU: halfword at offset[1]*16, sign- or zero-extended.
  - LW: whole word.
  - Undefined funct3 codes format as LW.
- Misaligned load: i_resultsrc_m=01 with either LH/LHU and offset[0]=1, or LW and offset != 00. In that case:
  - o_misaligned_w=1 for that WB cycle;
  - o_reg_write_w=0;
  - o_valid_w stays 1;
  - o_result_w carries the formatted value anyway, for debug.
- Misalignment is never flagged when i_resultsrc_m != 01.
- Write-enable rule: o_reg_write_w = i_valid_m & i_reg_write_m & !misaligned & (i_rd_m != 0). Writes to x0 are suppressed here.
- Counter: o_retired increments by 1, wrapping modulo 2^P_CNT_WIDTH, on each edge that captures a valid, non-misaligned instruction with no stall, flush or reset. A misaligned load does not retire.
- Simultaneous stall and flush: flush wins and the bubble is inserted.
- Reset mid-stall: reset wins, and outputs are 0 on the next cycle.

Decomposition:
- Shared package wb_pkg:
  - enum resultsrc_e {RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11};
  - enum load_funct3_e {LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101}.
- One sub-module, load_formatter (combinational): inputs raw word, offset and funct3; outputs the formatted data and a misaligned flag.
- The result mux is reused from the existing mux2 cells or written as a case on resultsrc_e.

Test Plan:
- Reset then one valid ALU op (resultsrc=00, alu=0x0000_1234, rd=5, reg_write=1) -> next cycle o_result_w=0x0000_1234, o_rd_w=5, o_reg_write_w=1, o_retired=1.
- LB and LBU, rdata=0x80FF_7F01:
  - LB at offset 3 -> o_result_w=0xFFFF_FF80.
  - LBU at offset 3 -> 0x0000_0080.
  - LH at offset 2 -> 0xFFFF_80FF.
- Misaligned: LW with alu=0x0000_1002 -> o_misaligned_w=1, o_reg_write_w=0, o_valid_w=1, o_retired unchanged.
- Stall and flush sequence:
  - Capture a JAL (pc+4=0x104, rd=1), then assert i_stall for 3 cycles with new inputs -> outputs hold 0x104 and rd=1; counter unchanged.
  - Then i_stall=1 and i_flush=1 together -> o_valid_w=0, o_reg_write_w=0.
- Writes to x0: LUI (imm=0xABCD_E000, rd=0) -> o_result_w=0xABCD_E000, o_reg_write_w=0, o_retired increments.
- Counter wrap and reset:
  - With P_CNT_WIDTH=4, retire 17 instructions -> o_retired=1.
  - Assert i_rst during a stall -> all outputs 0 on the next cycle.
